// File: rtl/nn_main_pkg.sv
// nn_main_pkg: shared widths, fixed Q8.8 weights and saturation for the 7-3-1 perceptron
package nn_main_pkg;
  localparam int DW = 17;
  localparam int FW = 8;
  localparam int AW = 30;
  localparam int NI = 7;
  localparam int NH = 3;
  typedef logic signed [DW-1:0] q_t;
  localparam logic signed [AW-1:0] SAT_MAX = 30'sd65535;
  localparam logic signed [AW-1:0] SAT_MIN = -30'sd65536;
  localparam q_t [NH-1:0][NI-1:0] W = {{NI{17'h00080}}, {NI{17'h1FF00}}, {NI{17'h00100}}};
  localparam q_t [NH-1:0] B = {17'h1FF00, 17'h00000, 17'h00000};
  localparam q_t [NH-1:0] V = {17'h00200, 17'h00100, 17'h00100};
  localparam q_t C = 17'h00000;
  function automatic q_t sat(input logic signed [AW-1:0] a);
    return a > SAT_MAX ? SAT_MAX[DW-1:0] : a < SAT_MIN ? SAT_MIN[DW-1:0] : a[DW-1:0];
  endfunction
endpackage

// File: rtl/nn_main_if.sv
// nn_main_if: clock enable, seven Q8.8 network inputs and the registered network output
interface nn_main_if;
  import nn_main_pkg::*;
  logic ce;
  q_t x1, x2, x3, x4, x5, x6, x7;
  q_t y_out;
  modport master(output ce, x1, x2, x3, x4, x5, x6, x7, input y_out);
  modport slave(input ce, x1, x2, x3, x4, x5, x6, x7, output y_out);
endinterface

// File: rtl/nn_neuron.sv
// nn_neuron: combinational multiply-accumulate with bias, 17-bit saturation and optional ReLU
module nn_neuron
  import nn_main_pkg::*;
#(
  parameter int N = NI,
  parameter q_t [N-1:0] WT = '0,
  parameter q_t BIAS = '0,
  parameter bit RELU = 1'b1
) (
  input  q_t [N-1:0] x,
  output q_t         y
);
  logic signed [2*DW-1:0] p;
  logic signed [AW-1:0] acc;
  q_t s;
  always_comb begin
    acc = AW'(BIAS);
    p = '0;
    for (int i = 0; i < N; i++) begin
      p = (2*DW)'($signed(x[i])) * (2*DW)'($signed(WT[i]));
      acc = acc + AW'(p >>> FW);
    end
    s = sat(acc);
    y = RELU && s[DW-1] ? '0 : s;
  end
endmodule

// File: rtl/nn_main.sv
// nn_main: fixed-weight 7-3-1 perceptron, 3-stage pipeline (inputs, hidden, output) gated by ce
module nn_main
  import nn_main_pkg::*;
(
  input logic       clk,
  input logic       rst_n,
  nn_main_if.slave  bus
);
  q_t [NI-1:0] xr;
  q_t [NH-1:0] hr, hn;
  q_t yn;
  for (genvar j = 0; j < NH; j++) begin : g_hid
    nn_neuron #(.N(NI), .WT(W[j]), .BIAS(B[j]), .RELU(1'b1)) u_h (.x(xr), .y(hn[j]));
  end
  nn_neuron #(.N(NH), .WT(V), .BIAS(C), .RELU(1'b0)) u_o (.x(hr), .y(yn));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      xr <= '0;
      hr <= '0;
      bus.y_out <= '0;
    end else if (bus.ce) begin
      xr <= {bus.x7, bus.x6, bus.x5, bus.x4, bus.x3, bus.x2, bus.x1};
      hr <= hn;
      bus.y_out <= yn;
    end
endmodule

// File: tb/tb_nn_main.sv
// tb_nn_main: directed vector table streamed through the pipeline plus reset/ce sequences
module tb_nn_main;
  import nn_main_pkg::*;
  typedef struct packed {
    q_t [6:0] x;
    q_t y;
  } vec_t;
  logic clk, rst_n;
  int nvec, nbad;
  vec_t tab[10];
  nn_main_if bus();
  nn_main dut(.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic drive(input q_t [6:0] v);
    bus.x1 = v[0]; bus.x2 = v[1]; bus.x3 = v[2]; bus.x4 = v[3];
    bus.x5 = v[4]; bus.x6 = v[5]; bus.x7 = v[6];
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input q_t exp);
    nvec++;
    if (bus.y_out !== exp) begin
      nbad++;
      $display("FAIL %s: y_out=%h expected %h", name, bus.y_out, exp);
    end
  endtask
  initial begin
    nvec = 0;
    nbad = 0;
    tab[0] = '{x: {17'd1, 17'd1, 17'd0, 17'd1, 17'd0, 17'd1, 17'd1}, y: 17'h00005};
    tab[1] = '{x: '0, y: 17'h00000};
    tab[2] = '{x: {7{17'h00100}}, y: 17'h00C00};
    tab[3] = '{x: {7{17'h1FF00}}, y: 17'h00700};
    tab[4] = '{x: {7{17'h0FFFF}}, y: 17'h0FFFF};
    tab[5] = '{x: {7{17'h00200}}, y: 17'h01A00};
    tab[6] = '{x: {7{17'h1FE00}}, y: 17'h00E00};
    tab[7] = '{x: {{6{17'h00000}}, 17'h00100}, y: 17'h00100};
    tab[8] = '{x: {7{17'h1FFFF}}, y: 17'h00007};
    tab[9] = '{x: {7{17'h10000}}, y: 17'h0FFFF};
    rst_n = 1'b0;
    bus.ce = 1'b1;
    drive({7{17'h0ABCD}});
    #2;
    for (int i = 0; i < 4; i++) begin
      drive({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
      step();
      check("reset_hold", '0);
    end
    drive('0);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("zero_after_reset", '0);
    end
    for (int i = 0; i < 12; i++) begin
      drive(i < 10 ? tab[i].x : '0);
      step();
      if (i >= 2) check($sformatf("table_%0d", i - 2), tab[i - 2].y);
    end
    step();
    check("drain_zero", '0);
    drive({7{17'h1FF00}});
    for (int i = 0; i < 3; i++) step();
    check("pre_hold_neg", 17'h00700);
    drive({7{17'h00100}});
    step();
    check("hold_first_edge", 17'h00700);
    bus.ce = 1'b0;
    drive('0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("ce_hold", 17'h00700);
    end
    bus.ce = 1'b1;
    step();
    check("resume_edge1", 17'h00700);
    step();
    check("resume_edge2", 17'h00C00);
    drive({7{17'h00100}});
    step();
    #2 rst_n = 1'b0;
    #1 check("async_reset_now", '0);
    for (int i = 0; i < 2; i++) begin
      step();
      check("reset_over_ce", '0);
    end
    drive('0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("inflight_discarded", '0);
    end
    drive({7{17'h00100}});
    step();
    drive('0);
    step();
    check("latency_edge2", '0);
    step();
    check("latency_edge3", 17'h00C00);
    step();
    check("latency_edge4", '0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule

// File: doc/nn_main.md
NN_MAIN -- requirements
Module: nn_main

Interface
REQ-001 SHALL expose: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL expose: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL expose: ce  input  1  clock enable; when low, every register holds its value.
REQ-004 SHALL expose: x1..x7  input  17 each  network inputs, signed two's-complement Q8.8 (1 sign, 8 integer, 8 fraction bits).
REQ-005 SHALL expose: y_out  output  17  network output, signed Q8.8, driven directly from a register.

Function
REQ-006 SHALL implement a fixed-weight 7-3-1 perceptron: h_j = ReLU(sat17(sum_i W[j][i]*x_i + B[j])) for j=1..3; y = sat17(sum_j V[j]*h_j + C).
REQ-007 SHALL use Q8.8 weights: W1[all] = +1.0 (0x00100); W2[all] = -1.0 (0x1FF00); W3[all] = +0.5 (0x00080); B = {0, 0, -1.0}; V = {+1.0, +1.0, +2.0}; C = 0.
REQ-008 SHALL form each product as full 34-bit signed, then arithmetic shift right by 8 (floor, no rounding).
REQ-009 SHALL accumulate each neuron in at least 30-bit signed, so the 7 products plus bias never overflow.
REQ-010 SHALL saturate each neuron sum to 17-bit signed range [-65536, 65535] (0x10000..0x0FFFF) before activation/output.
REQ-011 SHALL apply ReLU on hidden neurons: negative -> 0, else unchanged; the output neuron is linear, saturated only.
REQ-012 SHALL be a 3-stage pipeline advancing only on clock edges with ce=1: S1 registers x1..x7, S2 registers h1..h3, S3 registers y_out.
REQ-013 SHALL give latency of exactly 3 ce-qualified edges from input sample to y_out; throughput one vector per ce edge.
REQ-014 SHALL freeze all stages while ce=0; a vector resumes exactly where it stopped when ce returns high.
REQ-015 SHALL treat ce and inputs as synchronous; inputs are sampled only at ce=1 edges.

Reset
REQ-016 SHALL clear all pipeline registers (input, hidden, y_out) to 0 immediately on rst_n low, independent of clk and ce.
REQ-017 SHALL hold y_out = 0 while rst_n is low; reset has priority over ce.
REQ-018 SHALL discard any in-flight vector on reset mid-operation; first valid output appears 3 ce edges after the first post-reset sample.
REQ-019 SHALL produce y_out = 0 in steady state for all-zero inputs (h3 bias -1.0 clamps via ReLU).

Structure
REQ-020 SHALL place in a shared package: data width (17), fraction bits (8), accumulator width (30), neuron counts (7, 3), weight arrays W, B, V, C, and the saturation limits.
REQ-021 SHALL use one sub-module nn_neuron (parameterised input count, weights, bias, ReLU enable) for the multiply-accumulate-saturate datapath, instantiated 3x hidden and 1x output.
REQ-022 SHALL keep pipeline registers and ce gating in nn_main; nn_neuron is purely combinational.

Verification
REQ-023 Reset: rst_n=0 with arbitrary inputs and toggling clk -> y_out = 0x00000 throughout; all-zero inputs after release -> y_out stays 0.
REQ-024 Small raw values: x = {1,1,0,1,0,1,1} (raw LSBs), ce=1 -> y_out = 0x00005 on the 3rd edge; then zero inputs -> y_out returns to 0 three edges later.
REQ-025 Positive: all x = 0x00100 (1.0) -> h = {1792, 0, 640}; y_out = 0x00C00 (12.0) after 3 edges.
REQ-026 Negative: all x = 0x1FF00 (-1.0) -> h = {0, 1792, 0}; y_out = 0x00700 (7.0).
REQ-027 Saturation: all x = 0x0FFFF -> h1 = h3 = 65535, h2 = 0; y_out = 0x0FFFF (clamped, no wrap).
REQ-028 ce hold: apply the 1.0 vector, drop ce after 1 edge for 5 edges -> y_out unchanged; restore ce -> 0x00C00 after 2 more edges; assert rst_n=0 mid-pipeline -> y_out = 0 immediately.
